// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, keyboard command bytes and parity.
// Imported by the host transmitter and the PS/2 receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // PS/2 frames use odd parity over data plus parity bit.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-flop synchronizer for PS2_CLK/PS2_DAT plus registered falling-edge pulse.
// Ports: clk_i, rst_ni, ps2_clk_i, ps2_dat_i -> clk_s_o, dat_s_o, fall_o.
module ps2_sync_edge
  import ps2_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic fall_o
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q, dat_dly_q;
  logic fall_q;

  // Idle lines are high; resetting to 1 avoids a false edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      dat_dly_q  <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
      dat_dly_q  <= dat_sync_q;
      fall_q     <= clk_prev_q & ~clk_sync_q;
    end
  end

  // Levels delayed one stage so they line up with the registered fall pulse.
  assign clk_s_o = clk_prev_q;
  assign dat_s_o = dat_dly_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (request-to-send, 8N1+odd, ack).
// Ports: tx_valid/tx_data/tx_ready in, ps2 pins in, open-collector oe out, busy/done/err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s, dat_s, fall;

  ps2_sync_edge u_sync (
    .clk_i    (clk),
    .rst_ni   (reset),
    .ps2_clk_i(ps2_clk_in),
    .ps2_dat_i(ps2_dat_in),
    .clk_s_o  (clk_s),
    .dat_s_o  (dat_s),
    .fall_o   (fall)
  );

  ps2_state_e    state_q;
  logic [7:0]    data_q;
  logic          par_q;
  logic          nack_q;
  logic [3:0]    bit_q;
  logic [IW-1:0] inh_q;
  logic [TW-1:0] tmo_q;
  logic          clk_oe_q, dat_oe_q;
  logic          busy_q, done_q, err_q;

  // Device-clocked part of the frame, guarded by the timeout.
  logic timed;
  assign timed = (state_q == SEND) ||
                 (state_q == ACK) ||
                 (state_q == WAIT_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      nack_q   <= 1'b0;
      bit_q    <= '0;
      inh_q    <= '0;
      tmo_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (timed && (tmo_q == TMO_LAST)) begin
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        done_q   <= 1'b1;
        err_q    <= 1'b1;
        busy_q   <= 1'b0;
        state_q  <= IDLE;
      end else begin
        if (timed) tmo_q <= tmo_q + TW'(1);
        unique case (state_q)
          IDLE: begin
            tmo_q <= '0;
            inh_q <= '0;
            bit_q <= '0;
            if (tx_valid) begin
              data_q   <= tx_data;
              par_q    <= odd_parity(tx_data);
              clk_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_q == INH_LAST) begin
              dat_oe_q <= 1'b1;
              state_q  <= REQ;
            end else begin
              inh_q <= inh_q + IW'(1);
            end
          end
          REQ: begin
            // Start bit already low; releasing clk hands control to the device.
            clk_oe_q <= 1'b0;
            bit_q    <= '0;
            tmo_q    <= '0;
            state_q  <= SEND;
          end
          SEND: begin
            if (fall) begin
              bit_q <= bit_q + 4'd1;
              unique case (1'b1)
                (bit_q < 4'd8):  dat_oe_q <= ~data_q[bit_q[2:0]];
                (bit_q == 4'd8): dat_oe_q <= ~par_q;
                default: begin
                  dat_oe_q <= 1'b0;
                  state_q  <= ACK;
                end
              endcase
            end
          end
          ACK: begin
            if (fall) begin
              nack_q  <= dat_s;
              state_q <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clk_s && dat_s) begin
              done_q  <= 1'b1;
              err_q   <= nack_q;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready   = ~busy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the processor to the keyboard over the same PS2_CLK/PS2_DAT pins the existing PS/2 receiver listens on. It performs the host request-to-send sequence, shifts out the byte, parity and stop bit on device-generated clocks, and checks the device's line acknowledge. Pins are open-collector: the block only drives low through output enables; the top level builds the tristates.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles PS2_CLK is held low before start (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles from clock release to frame end (15 ms).
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- tx_valid  in  1  command byte request.
- tx_data  in  8  command byte.
- tx_ready  out  1  block idle, accepts a byte.
- ps2_clk_in  in  1  PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  transmit in progress; receiver discards frames while high.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  valid with done: 1 = no ack or timeout.

## Operation
- Reset values: tx_ready=1, busy=0, done=0, err=0, ps2_clk_oe=0, ps2_dat_oe=0, state IDLE, counters 0.
- Pins pass a 2-flop synchronizer; falling edge of synced clock = fall (1-cycle pulse).
- Accept: tx_valid && tx_ready in IDLE; tx_data latched, odd parity = ~^tx_data latched; tx_ready low next cycle; tx_valid while busy ignored.
- States:
  - IDLE: lines released; accept → INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles → REQ.
  - REQ: clk_oe=1, dat_oe=1 for exactly 1 cycle → SEND (start bit 0 on line).
  - SEND: clk_oe=0, dat_oe held; bit counter n starts 0; on each fall: n=0..7 dat_oe=~tx_data[n] (LSB first), n=8 dat_oe=~parity, n=9 dat_oe=0 (stop, released) → ACK.
  - ACK: on next fall sample synced data: 0 → ack_ok, 1 → nack; → WAIT_IDLE.
  - WAIT_IDLE: wait synced clk=1 and dat=1 → IDLE with done=1, err=nack.
- Timeout counter starts at SEND entry, cleared on IDLE; reaching TIMEOUT_CYCLES in SEND/ACK/WAIT_IDLE: release both lines, done=1, err=1, → IDLE.
- busy=1 in every state except IDLE; tx_ready=~busy.

## Timing
- Accept to clk_oe=1: 1 cycle (registered outputs).
- clk_oe low for exactly INHIBIT_CYCLES+1 cycles (INHIBIT + REQ); dat_oe rises 1 cycle before clk_oe falls.
- Pin falling edge to fall pulse: 3 cycles; dat_oe update 1 cycle after fall (well inside device's clock-low half period).
- done asserted in the cycle state returns to IDLE; tx_ready=1 same cycle; new byte accepted that cycle.
- Reset low mid-frame: both oe drop to 0 asynchronously, no done pulse.
- Fall pulses in IDLE/INHIBIT/REQ ignored (keyboard traffic during inhibit is aborted by the device).
- Device drops lines before stop: no special handling; timeout or nack covers it.

## Structure
- Package ps2_pkg: state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE), command constants (CMD_SET_LED 8'hED, CMD_RESET 8'hFF, CMD_ENABLE 8'hF4), odd-parity function; shared with receiver.
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge pulse for clk and data, reused by the receiver.

## Test plan
Bench uses INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, behavioural device model clocking at 20-cycle half period.
- Send 0xED, device acks → clk_oe low 9 cycles, bits on line 0,1,0,1,1,0,1,1,1 (start, LSB first), parity 1, stop 1; done=1, err=0.
- Send 0xF4 → parity bit 0; 0x00 → parity 1; device-sampled byte equals tx_data.
- Device never drives ack low → done=1, err=1 after 11th fall and idle lines.
- Device never clocks → done=1, err=1 exactly 2000 cycles after SEND entry; both oe=0.
- reset low during bit 4 → oe=0 immediately, tx_ready=1 after release, next 0xFF sends cleanly.
- tx_valid pulsed while busy → ignored; tx_valid held through done → second frame starts the cycle tx_ready returns.
